// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter.
// Holds the FSM state encoding, the requester indices and the hold-counter width.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int HOLD_W  = 4;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/datapath bundle between four requesters and the arbiter; master = requester side.
// No backpressure: requests are level-held, and the arbiter outputs are registered.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  import mux_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic [WIDTH-1:0]   data_c;
  logic [WIDTH-1:0]   data_d;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         sel;
  logic               enable;
  logic [WIDTH-1:0]   y;
  logic               y_valid;

  modport master (
    output req, data_a, data_b, data_c, data_d,
    input  grant, sel, enable, y, y_valid
  );

  modport slave (
    input  req, data_a, data_b, data_c, data_d,
    output grant, sel, enable, y, y_valid
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search of req starting at ptr; zero latency.
// No state and no backpressure; any=0 means nothing is requesting.
module mux_rr_arbiter_rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         winner,
  output logic [NUM_REQ-1:0] winner_onehot
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner        = ptr;
    winner_onehot = '0;
    found         = 1'b0;
    idx           = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) begin
      winner_onehot[winner] = 1'b1;
    end
    any = found;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 datapath; grant/sel/enable one cycle after req, y one more.
// No backpressure: an owner keeps the datapath until it drops req or hits MAX_HOLD with others waiting.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [1:0]         sel_q, sel_nxt;
  logic               enable_q, enable_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [WIDTH-1:0]   y_q, data_sel;
  logic               y_valid_q;

  logic               pick_any;
  logic [1:0]         pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               others_any;
  logic               take;

  mux_rr_arbiter_rr_pick u_pick (
    .req           (bus.req),
    .ptr           (ptr),
    .any           (pick_any),
    .winner        (pick_winner),
    .winner_onehot (pick_onehot)
  );

  assign others_any = |(bus.req & ~grant_q);

  // A forced release can use the plain pick: ptr already sits past the owner,
  // so the owner is searched last and any other requester wins first.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    sel_nxt    = sel_q;
    enable_nxt = enable_q;
    hold_nxt   = hold_cnt;
    ptr_nxt    = ptr;
    take       = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt  = '0;
        enable_nxt = 1'b0;
        take       = pick_any;
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            enable_nxt = 1'b0;
            hold_nxt   = '0;
          end
        end else if (hold_cnt >= HOLD_MAX) begin
          if (others_any) begin
            take = 1'b1;
          end else begin
            hold_nxt = HOLD_W'(1);
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        grant_nxt  = '0;
        enable_nxt = 1'b0;
      end
    endcase
    if (take) begin
      state_nxt  = GRANT;
      grant_nxt  = pick_onehot;
      sel_nxt    = pick_winner;
      enable_nxt = 1'b1;
      hold_nxt   = HOLD_W'(1);
      ptr_nxt    = pick_winner + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      sel_q    <= IDX_A;
      enable_q <= 1'b0;
      ptr      <= IDX_A;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      sel_q    <= sel_nxt;
      enable_q <= enable_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    data_sel = bus.data_a;
    case (sel_q)
      IDX_A:   data_sel = bus.data_a;
      IDX_B:   data_sel = bus.data_b;
      IDX_C:   data_sel = bus.data_c;
      IDX_D:   data_sel = bus.data_d;
      default: data_sel = bus.data_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      if (enable_q) begin
        y_q <= data_sel;
      end
      y_valid_q <= enable_q;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.enable  = enable_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with WIDTH=4, MAX_HOLD=4.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  mux_rr_arbiter_if #(.WIDTH(4)) bus ();

  mux_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic e, input logic v, input logic [3:0] yy);
    chk({tag, "/grant"},   16'(bus.grant),   16'(g));
    chk({tag, "/sel"},     16'(bus.sel),     16'(s));
    chk({tag, "/enable"},  16'(bus.enable),  16'(e));
    chk({tag, "/y_valid"}, 16'(bus.y_valid), 16'(v));
    chk({tag, "/y"},       16'(bus.y),       16'(yy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int owner;
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    bus.req     = 4'b1111;
    bus.data_a  = 4'h1;
    bus.data_b  = 4'h2;
    bus.data_c  = 4'h3;
    bus.data_d  = 4'h4;

    // reset held with every requester active
    tick(); expect_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
    tick(); expect_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // fair rotation: each owner exactly MAX_HOLD cycles, y one cycle behind
    for (int k = 0; k < 17; k++) begin
      tick();
      owner = (k / 4) % 4;
      if (k == 0)
        expect_out($sformatf("rot%0d", k), 4'(1 << owner), 2'(owner), 1'b1, 1'b0, 4'h0);
      else
        expect_out($sformatf("rot%0d", k), 4'(1 << owner), 2'(owner), 1'b1, 1'b1,
                   4'(((k - 1) / 4) % 4 + 1));
    end

    // early release: A drops req after 2 cycles of ownership, D takes over with no bubble
    bus.req = 4'b1001;
    tick(); expect_out("early_a", 4'b0001, 2'd0, 1'b1, 1'b1, 4'h1);
    bus.req = 4'b1000;
    tick(); expect_out("early_d0", 4'b1000, 2'd3, 1'b1, 1'b1, 4'h1);
    tick(); expect_out("early_d1", 4'b1000, 2'd3, 1'b1, 1'b1, 4'h4);

    // release to idle: sel holds, one trailing y_valid
    bus.req = 4'b0000;
    tick(); expect_out("idle0", 4'b0000, 2'd3, 1'b0, 1'b1, 4'h4);
    tick(); expect_out("idle1", 4'b0000, 2'd3, 1'b0, 1'b0, 4'h4);

    // single requester C across the hold-limit boundary
    bus.data_c = 4'hA;
    bus.req    = 4'b0100;
    tick(); expect_out("solo0", 4'b0100, 2'd2, 1'b1, 1'b0, 4'h4);
    for (int k = 1; k < 6; k++) begin
      tick(); expect_out($sformatf("solo%0d", k), 4'b0100, 2'd2, 1'b1, 1'b1, 4'hA);
    end
    bus.req = 4'b0000;
    tick(); expect_out("solo_rel0", 4'b0000, 2'd2, 1'b0, 1'b1, 4'hA);
    tick(); expect_out("solo_rel1", 4'b0000, 2'd2, 1'b0, 1'b0, 4'hA);

    // pointer order: after B, simultaneous A and C resolve to C
    bus.req = 4'b0010;
    tick(); expect_out("ptr_b", 4'b0010, 2'd1, 1'b1, 1'b0, 4'hA);
    bus.req = 4'b0101;
    tick(); expect_out("ptr_c", 4'b0100, 2'd2, 1'b1, 1'b1, 4'h2);
    bus.req = 4'b0001;
    tick(); expect_out("ptr_a", 4'b0001, 2'd0, 1'b1, 1'b1, 4'hA);

    // reset while pointer is at B: A must win over D afterwards
    rst_n   = 1'b0;
    bus.req = 4'b1001;
    tick(); expect_out("mrst_a", 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;
    tick(); expect_out("mrst_a_rel", 4'b0001, 2'd0, 1'b1, 1'b0, 4'h0);

    // reset during D's grant
    bus.req = 4'b1000;
    tick(); expect_out("mrst_d_own", 4'b1000, 2'd3, 1'b1, 1'b1, 4'h1);
    rst_n = 1'b0;
    tick(); expect_out("mrst_d", 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
    rst_n   = 1'b1;
    bus.req = 4'b1001;
    tick(); expect_out("mrst_d_rel", 4'b0001, 2'd0, 1'b1, 1'b0, 4'h0);

    bus.req = 4'b0000;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
